obstacle_sprite_loader: RTL



---
 rtl/obstacle_sprite_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/obstacle_sprite_loader.sv
// Streams one 16x16 sprite (2-bit palette codes) into a sprite RAM.
// A start request latches the sprite slot; each of the 16 rows arrives as a 32-bit word over a
// valid/ready handshake and is shifted out one pixel per cycle as a RAM write.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   start_i, sid_i - load request and target sprite slot (sampled when the request is accepted)
//   abort_i        - cancel any load in progress; wins over every other input
//   wr_valid_i, wr_data_i, wr_ready_o - row word handshake; pixel col i is wr_data_i[2i+1:2i]
//   we_o, addr_w_o, pixel_out_o       - registered sprite RAM write port
//   busy_o         - high whenever a load is in progress (any state but idle)
//   done_o         - one-cycle pulse after the final pixel write
//   start_err_o    - sticky: a start arrived while busy; cleared by the next accepted start
module obstacle_sprite_loader #(
  parameter int unsigned ADDR  = 10,
  parameter int unsigned SID_W = ADDR - 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [SID_W-1:0] sid_i,
  input  logic             abort_i,
  input  logic             wr_valid_i,
  input  logic [31:0]      wr_data_i,
  output logic             wr_ready_o,
  output logic             we_o,
  output logic [ADDR-1:0]  addr_w_o,
  output logic [1:0]       pixel_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             start_err_o
);

  typedef enum logic [1:0] {StIdle, StWaitRow, StShift, StDone} state_e;

  state_e           state_q;
  logic [SID_W-1:0] sid_q;
  logic [3:0]       row_q;
  logic [3:0]       col_q;
  logic [29:0]      shift_q;     // pixels of the current row not yet written
  logic             we_q;
  logic [ADDR-1:0]  addr_q;
  logic [1:0]       pixel_q;
  logic             start_err_q;

  logic [3:0] col_inc;
  assign col_inc = col_q + 4'd1;

  assign wr_ready_o  = (state_q == StWaitRow);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign we_o        = we_q;
  assign addr_w_o    = addr_q;
  assign pixel_out_o = pixel_q;
  assign start_err_o = start_err_q;

  // col_q tracks the column currently presented on the write port, so the handshake edge
  // already issues col 0 and SHIFT spans exactly 16 write cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sid_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      shift_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      pixel_q     <= '0;
      start_err_q <= 1'b0;
    end else if (abort_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
    end else begin
      if (start_i && (state_q != StIdle)) begin
        start_err_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start_i) begin
            sid_q       <= sid_i;
            row_q       <= '0;
            start_err_q <= 1'b0;
            state_q     <= StWaitRow;
          end
        end
        StWaitRow: begin
          if (wr_valid_i) begin
            shift_q <= wr_data_i[31:2];
            pixel_q <= wr_data_i[1:0];
            addr_q  <= ADDR'({sid_q, row_q, 4'd0});
            we_q    <= 1'b1;
            col_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (col_q == 4'd15) begin
            we_q <= 1'b0;
            if (row_q == 4'd15) begin
              state_q <= StDone;
            end else begin
              row_q   <= row_q + 4'd1;
              state_q <= StWaitRow;
            end
          end else begin
            col_q   <= col_inc;
            pixel_q <= shift_q[1:0];
            shift_q <= {2'b00, shift_q[29:2]};
            addr_q  <= ADDR'({sid_q, row_q, col_inc});
            we_q    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
